qam16_slicer: RTL and testbench
===============================

# qam16_slicer

Streaming 16-QAM hard-decision slicer that sits directly downstream of the FFT. It consumes one Q2.15 complex bin per handshake and emits:
- the Gray-coded 4-bit symbol,
- the decided constellation point,
- the error vector.

It also accumulates per-frame squared error magnitude (EVM numerator) over each NFFT-sample frame.

## Interface
- W, 17, sample width per component; signed Q2.15 (bit [W-1] sign)
- NFFT, 64, samples per frame
- THRESH, 20724, decision threshold, Q2.15 of 2/sqrt(10), truncated
- LVL1, 10362, inner level, Q2.15 of 1/sqrt(10)
- LVL3, 31086, outer level, Q2.15 of 3/sqrt(10)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_re, in_im  in  W  signed input bin
- in_sof  in  1  input sample is frame index 0 (realigns counter)
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output
- out_sym  out  4  {I[1:0], Q[1:0]} Gray code
- out_re, out_im  out  W  decided point (±LVL1/±LVL3)
- err_re, err_im  out  W+1  signed input minus decided point
- out_last  out  1  output sample is frame index NFFT-1
- frame_err_valid  out  1  one-cycle pulse; frame_err is valid
- frame_err  out  2(W+1)+1+clog2(NFFT)  sum over frame of err_re²+err_im²

## Operation
- Per-axis decision on component x, signed compare:
  - x < -THRESH → -LVL3, code 00
  - -THRESH ≤ x < 0 → -LVL1, code 01
  - 0 ≤ x < THRESH → +LVL1, code 11
  - x ≥ THRESH → +LVL3, code 10
- err = x - level, computed at W+1 bits. No saturation; the range is guaranteed to fit.
- Pipeline:
  - Stage 1 registers the input, in_sof, and both decisions.
  - Stage 2 registers the symbol, point, and error, and sets out_last.
- Global advance: en = !out_valid || out_ready; in_ready = en (combinational). Both stages shift on en, and bubbles propagate as invalid.
- Frame counter idx (clog2(NFFT) bits) advances on each output handshake (out_valid && out_ready).
  - out_last = (sample's effective idx == NFFT-1).
  - An output sample whose sof flag is set has effective idx 0. The counter continues from 1 after it.
  - Wraps NFFT-1 → 0.
- Accumulator acc advances on each output handshake:
  - sof sample: acc ← e², where e² = err_re²+err_im².
  - last sample: frame_err ← acc + e², frame_err_valid pulses, acc ← 0.
  - otherwise: acc ← acc + e².
- A partial frame cut short by sof produces no pulse; its accumulation is discarded.
- A sample with both sof and last (NFFT=1 only) counts as last, with frame_err = e².
- frame_err_valid is a status pulse with no backpressure. frame_err holds its value until the next pulse.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): all outputs, pipeline regs, idx, acc, frame_err = 0. in_ready = 1 after reset.
- Reset mid-frame discards all in-flight samples and the partial accumulation.
- Latency: input handshake at cycle N → out_valid at N+2 when out_ready is held high. Throughput is 1 sample/cycle.
- With out_valid=1 and out_ready=0, all outputs are held stable, in_ready=0, and no input is accepted.
- frame_err_valid asserts the cycle after the out_last handshake.

## Structure
- Add to the shared complex_pkg:
  - the Q2.15 sample typedef (W=17);
  - the 16-QAM constants THRESH, LVL1, LVL3;
  - the Gray-code localparams.
- Sub-module qam16_axis_decide (combinational: x → level, code, err), instantiated twice (I and Q).
- The top holds the pipeline, handshake, frame counter, and accumulator.

## Test plan
- Reset: assert rst_n=0 mid-frame with out_valid=1 → out_valid, out_last, frame_err_valid, frame_err all 0, and in_ready=1. The first frame after release closes after 64 samples.
- Ideal point: in (10362, -31086) → 2 cycles later out_sym=4'b1100, out_re=10362, out_im=-31086, err=(0,0).
- Thresholds on re (im=0):
  - 20724 → code 10
  - 20723 → 11
  - 0 → 11
  - -1 → 01
  - -20724 → 01
  - -20725 → 00
  - err for 20723 = 10361.
- Backpressure: continuous input, out_ready low for 5 cycles → in_ready low, outputs stable, no samples lost or duplicated, order preserved.
- Frame EVM: 64 samples at (LVL1+100, LVL1-100) → out_last on the 64th sample only, a single frame_err_valid pulse, frame_err=1280000.
- Realign: in_sof on sample 10 of a frame → no pulse for the partial frame, out_last on sof sample +63, frame_err covers only those 64 samples.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared complex-sample types and 16-QAM constellation constants for the
// frequency-domain receive path.
package complex_pkg;

  localparam int W    = 17;
  localparam int EW   = W + 1;
  localparam int NFFT = 64;
  localparam int IDXW = $clog2(NFFT);
  localparam int FEW  = 2 * EW + 1 + IDXW;

  typedef logic signed [W-1:0]  sample_t;
  typedef logic signed [EW-1:0] err_t;
  typedef logic [1:0]           gray_t;
  typedef logic [IDXW-1:0]      idx_t;
  typedef logic [FEW-1:0]       frame_err_t;

  // Levels are 1/sqrt(10) and 3/sqrt(10); the threshold sits midway at 2/sqrt(10).
  localparam sample_t THRESH     = 17'sd20724;
  localparam sample_t NEG_THRESH = -17'sd20724;
  localparam sample_t LVL1       = 17'sd10362;
  localparam sample_t LVL3       = 17'sd31086;

  localparam gray_t GRAY_NEG3 = 2'b00;
  localparam gray_t GRAY_NEG1 = 2'b01;
  localparam gray_t GRAY_POS1 = 2'b11;
  localparam gray_t GRAY_POS3 = 2'b10;

  typedef struct packed {
    gray_t   code;
    sample_t level;
    err_t    err;
  } axis_dec_t;

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(NFFT - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/qam16_axis_decide.sv
// Single-axis 16-QAM hard decision: picks the nearest level, its Gray code,
// and the residual error at one extra bit of headroom.
module qam16_axis_decide
  import complex_pkg::*;
(
  input  logic signed [W-1:0] x,
  output axis_dec_t           dec
);

  always_comb begin
    dec = '0;
    if (x < NEG_THRESH) begin
      dec.code  = GRAY_NEG3;
      dec.level = -LVL3;
    end else if (x < 17'sd0) begin
      dec.code  = GRAY_NEG1;
      dec.level = -LVL1;
    end else if (x < THRESH) begin
      dec.code  = GRAY_POS1;
      dec.level = LVL1;
    end else begin
      dec.code  = GRAY_POS3;
      dec.level = LVL3;
    end
    dec.err = {x[W-1], x} - {dec.level[W-1], dec.level};
  end

endmodule

// File: rtl/qam16_slicer.sv
// Streaming 16-QAM slicer: two-stage pipeline with a global stall, per-frame
// sample counter and squared-error accumulator for EVM.
module qam16_slicer
  import complex_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_sym,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic signed [EW-1:0] err_re,
  output logic signed [EW-1:0] err_im,
  output logic                out_last,
  output logic                frame_err_valid,
  output logic [FEW-1:0]      frame_err
);

  axis_dec_t  dec_i, dec_q;
  axis_dec_t  s1_i, s1_q;
  logic       s1_valid, s1_sof;
  logic       out_sof;
  idx_t       idx, cur_eff, next_eff;
  logic       en, out_fire;
  logic signed [2*EW-1:0] sq_re, sq_im;
  frame_err_t e2, acc;

  qam16_axis_decide u_dec_i (.x(in_re), .dec(dec_i));
  qam16_axis_decide u_dec_q (.x(in_im), .dec(dec_q));

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign out_fire = out_valid && out_ready;

  // idx is the index of the sample in stage 2 unless that sample carries sof;
  // the sample entering stage 2 continues from whatever leaves this edge.
  assign cur_eff  = out_sof ? '0 : idx;
  assign next_eff = s1_sof ? '0 : (out_fire ? idx_inc(cur_eff) : idx);

  assign sq_re = err_re * err_re;
  assign sq_im = err_im * err_im;
  assign e2    = frame_err_t'($unsigned(sq_re)) + frame_err_t'($unsigned(sq_im));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_sym   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      err_re    <= '0;
      err_im    <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sof    <= in_valid && in_sof;
      s1_i      <= dec_i;
      s1_q      <= dec_q;
      out_valid <= s1_valid;
      out_sof   <= s1_valid && s1_sof;
      out_sym   <= {s1_i.code, s1_q.code};
      out_re    <= s1_i.level;
      out_im    <= s1_q.level;
      err_re    <= s1_i.err;
      err_im    <= s1_q.err;
      out_last  <= s1_valid && (next_eff == idx_t'(NFFT - 1));
    end
  end

  // A sof sample restarts the sum, silently dropping any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      acc             <= '0;
      frame_err       <= '0;
      frame_err_valid <= 1'b0;
    end else begin
      frame_err_valid <= 1'b0;
      if (out_fire) begin
        idx <= idx_inc(cur_eff);
        if (out_last) begin
          frame_err       <= (out_sof ? '0 : acc) + e2;
          frame_err_valid <= 1'b1;
          acc             <= '0;
        end else if (out_sof) begin
          acc <= e2;
        end else begin
          acc <= acc + e2;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_slicer.sv
// Scoreboard bench for qam16_slicer: directed vectors push expected results,
// a negedge monitor pops and compares every output and frame-error pulse.
module tb_qam16_slicer;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, in_ready, in_sof;
  logic signed [16:0]  in_re, in_im;
  logic                out_valid, out_ready, out_last;
  logic [3:0]          out_sym;
  logic signed [16:0]  out_re, out_im;
  logic signed [17:0]  err_re, err_im;
  logic                frame_err_valid;
  logic [42:0]         frame_err;

  typedef struct {
    logic [3:0]         sym;
    logic signed [16:0] re, im;
    logic signed [17:0] er, ei;
    logic               last;
  } exp_t;

  exp_t        exp_q[$];
  longint      fexp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tb_idx = 0;
  longint      tb_acc = 0;

  logic               stall_prev = 1'b0;
  logic [3:0]         snap_sym;
  logic signed [16:0] snap_re;
  logic signed [17:0] snap_er;
  logic               snap_last;

  localparam logic signed [16:0] L1 = 17'sd10362;
  localparam logic signed [16:0] L3 = 17'sd31086;

  qam16_slicer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_re(out_re), .out_im(out_im),
    .err_re(err_re), .err_im(err_im), .out_last(out_last),
    .frame_err_valid(frame_err_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Drives one sample (called just after a negedge), waits for acceptance,
  // then records the expected output and updates the frame model.
  task automatic applyStimulus(input logic signed [16:0] re, input logic signed [16:0] im,
                               input logic sof, input logic [3:0] sym,
                               input logic signed [16:0] ore, input logic signed [16:0] oim,
                               input logic signed [17:0] er, input logic signed [17:0] ei);
    int     guard = 0;
    int     eff;
    longint e2;
    exp_t   e;
    in_re = re; in_im = im; in_sof = sof; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    eff    = sof ? 0 : tb_idx;
    tb_idx = (eff + 1) % 64;
    e2     = longint'(er) * longint'(er) + longint'(ei) * longint'(ei);
    e.sym = sym; e.re = ore; e.im = oim; e.er = er; e.ei = ei; e.last = (eff == 63);
    exp_q.push_back(e);
    if (eff == 63) begin
      fexp_q.push_back((sof ? 0 : tb_acc) + e2);
      tb_acc = 0;
    end else if (sof) begin
      tb_acc = e2;
    end else begin
      tb_acc = tb_acc + e2;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_q.size() != 0 || fexp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain_exp_q", exp_q.size(), 0);
    checkOutput("drain_fexp_q", fexp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 0);
        if (stall_prev) begin
          checkOutput("stall_sym", out_sym, snap_sym);
          checkOutput("stall_re", out_re, snap_re);
          checkOutput("stall_err_re", err_re, snap_er);
          checkOutput("stall_last", out_last, snap_last);
        end
      end
      stall_prev = out_valid && !out_ready;
      snap_sym = out_sym; snap_re = out_re; snap_er = err_re; snap_last = out_last;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_sym", out_sym, e.sym);
          checkOutput("out_re", out_re, e.re);
          checkOutput("out_im", out_im, e.im);
          checkOutput("err_re", err_re, e.er);
          checkOutput("err_im", err_im, e.ei);
          checkOutput("out_last", out_last, e.last);
        end
      end
      if (frame_err_valid) begin
        if (fexp_q.size() == 0) checkOutput("unexpected_frame_pulse", 1, 0);
        else checkOutput("frame_err", longint'(frame_err), fexp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_frame_err", longint'(frame_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] ideal point and thresholds");
    applyStimulus(L1, -L3, 1'b0, 4'b1100, L1, -L3, 18'sd0, 18'sd0);
    applyStimulus(17'sd20724,  17'sd0, 1'b0, 4'b1011,  L3, L1, -18'sd10362, -18'sd10362);
    applyStimulus(17'sd20723,  17'sd0, 1'b0, 4'b1111,  L1, L1,  18'sd10361, -18'sd10362);
    applyStimulus(17'sd0,      17'sd0, 1'b0, 4'b1111,  L1, L1, -18'sd10362, -18'sd10362);
    applyStimulus(-17'sd1,     17'sd0, 1'b0, 4'b0111, -L1, L1,  18'sd10361, -18'sd10362);
    applyStimulus(-17'sd20724, 17'sd0, 1'b0, 4'b0111, -L1, L1, -18'sd10362, -18'sd10362);
    applyStimulus(-17'sd20725, 17'sd0, 1'b0, 4'b0011, -L3, L1,  18'sd10361, -18'sd10362);
    idle();
    waitDrain();

    $display("[TB] backpressure");
    fork
      begin
        for (int k = 1; k <= 10; k++)
          applyStimulus(L1 + 17'(k), -L3 - 17'(k), 1'b0, 4'b1100, L1, -L3, 18'(k), -18'(k));
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] frame EVM");
    for (int k = 0; k < 64; k++)
      applyStimulus(L1 + 17'sd100, L1 - 17'sd100, k == 0, 4'b1111, L1, L1, 18'sd100, -18'sd100);
    idle();
    waitDrain();

    $display("[TB] realign");
    for (int k = 0; k < 10; k++)
      applyStimulus(L1 + 17'sd100, L1 - 17'sd100, k == 0, 4'b1111, L1, L1, 18'sd100, -18'sd100);
    for (int k = 0; k < 64; k++)
      applyStimulus(L1 + 17'sd50, L1 + 17'sd50, k == 0, 4'b1111, L1, L1, 18'sd50, 18'sd50);
    idle();
    waitDrain();

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 5; k++)
      applyStimulus(L1 + 17'sd100, L1 - 17'sd100, k == 0, 4'b1111, L1, L1, 18'sd100, -18'sd100);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_re = L1; in_im = L1; in_sof = 1'b0;
    repeat (4) @(negedge clk);
    idle();
    checkOutput("prereset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_frame_err_valid", frame_err_valid, 0);
    checkOutput("rst_frame_err", longint'(frame_err), 0);
    checkOutput("rst_in_ready", in_ready, 1);
    exp_q.delete();
    fexp_q.delete();
    tb_idx = 0;
    tb_acc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++)
      applyStimulus(L1 + 17'sd100, L1 - 17'sd100, 1'b0, 4'b1111, L1, L1, 18'sd100, -18'sd100);
    idle();
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
